seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV, default 50000, cycles each digit is lit per slot, legal range >=2.
REQ-003 Parameter GAP, default 16, all-off cycles between slots (anti-ghosting), legal range >=1.
REQ-004 Parameter INVERT, default 1; 1 = seg, dp and an active-low; 0 = active-high.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 value  input  4*DIGITS  hex nibbles; nibble k drives digit k; digit 0 is least significant.
REQ-008 dp_in  input  DIGITS  decimal point per digit, 1 = lit, logical polarity.
REQ-009 lz_en  input  1  leading-zero suppression enable, sampled every cycle.
REQ-010 load  input  1  request to capture value/dp_in; accepted only when ready=1.
REQ-011 ready  output  1  1 = no update pending, load accepted.
REQ-012 seg  output  7  segment pattern of the lit digit.
REQ-013 dp  output  1  decimal point of the lit digit.
REQ-014 an  output  DIGITS  digit enables, one-hot (or all-off) in logical terms.

Function
REQ-015 Segment encoding SHALL come from one shared hex2digit instance, INVERT passed through; no private table.
REQ-016 Registers: active (value+dp shown), shadow (accepted, not yet shown), pending flag, digit index idx, slot counter cnt, state.
REQ-017 FSM states: GAP (all an/seg/dp off), SHOW (digit idx lit); GAP lasts exactly GAP cycles, SHOW exactly DIV cycles.
REQ-018 GAP -> SHOW when cnt reaches GAP-1; SHOW -> GAP when cnt reaches DIV-1; cnt clears on every transition.
REQ-019 idx increments on SHOW -> GAP, wrapping DIGITS-1 -> 0; frame = DIGITS*(DIV+GAP) cycles.
REQ-020 an, seg, dp SHALL be registered and change on the same edge as state/idx; exactly one an active in SHOW, none in GAP.
REQ-021 load with ready=1: shadow <= value/dp_in, pending <= 1, ready <= 0 on that edge.
REQ-022 load with ready=0: ignored, shadow unchanged, no error flag.
REQ-023 Frame boundary = GAP -> SHOW transition with idx=0; if pending, active <= shadow on that edge so digit 0 of that frame shows new data; pending <= 0, ready <= 1 same edge.
REQ-024 load in the same cycle as a boundary with ready=1: captured to shadow, applied at the following boundary, never the current one.
REQ-025 No tearing: active SHALL change only at a frame boundary.
REQ-026 Leading-zero suppression (lz_en=1): digit k blanked (an still cycles, seg/dp off) when all nibbles k..DIGITS-1 of active are 0 and k>0; digit 0 is never blanked.
REQ-027 A blanked digit with its dp bit set SHALL still light dp.
REQ-028 Polarity: physical output = logical XOR INVERT for an and dp; seg taken from hex2digit directly when lit, all-off pattern when dark.

Reset
REQ-029 rst=1 on an edge: state=GAP, cnt=0, idx=0, active=0, shadow=0, pending=0, ready=1.
REQ-030 Reset outputs: an, seg, dp all off (INVERT=1: an all 1s, seg 7'b1111111, dp 1).
REQ-031 Reset mid-slot or with an update pending SHALL discard the pending update; first SHOW (digit 0) begins GAP cycles after rst falls.
REQ-032 load asserted while rst=1 SHALL be ignored.

Verification (DIGITS=4, DIV=4, GAP=1, INVERT=1)
REQ-033 Reset release -> 1 GAP cycle, then an=4'b1110 for 4 cycles, seg=7'b1000000 (0), ready=1.
REQ-034 Free run -> an sequence 1110,1111,1101,1111,1011,1111,0111,1111; 20-cycle frame; never two an active.
REQ-035 load value=16'h12AF mid-frame -> ready=0 next cycle; digits keep old data until boundary; then digit0 seg=7'b0001110 (F), digit3 7'b1111001 (1); ready=1.
REQ-036 Second load while ready=0 with 16'hFFFF -> ignored; display shows 16'h12AF after boundary.
REQ-037 lz_en=1, value=16'h0050 -> digits 3,2 dark (seg 7'b1111111), digit1 7'b0010010 (5), digit0 7'b1000000; value=0 -> only digit0 lit.
REQ-038 rst pulse with pending update during SHOW of digit 2 -> outputs off next cycle, active=0, ready=1, scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed hex 7-segment scanner with gap blanking, frame-synchronous updates and leading-zero suppression.
module hex2digit #(
  parameter bit INVERT = 1'b1
) (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  logic [6:0] raw;
  always_comb begin
    raw = 7'h00;
    case (nib)
      4'h0: raw = 7'h3F;
      4'h1: raw = 7'h06;
      4'h2: raw = 7'h5B;
      4'h3: raw = 7'h4F;
      4'h4: raw = 7'h66;
      4'h5: raw = 7'h6D;
      4'h6: raw = 7'h7D;
      4'h7: raw = 7'h07;
      4'h8: raw = 7'h7F;
      4'h9: raw = 7'h6F;
      4'hA: raw = 7'h77;
      4'hB: raw = 7'h7C;
      4'hC: raw = 7'h39;
      4'hD: raw = 7'h5E;
      4'hE: raw = 7'h79;
      4'hF: raw = 7'h71;
      default: raw = 7'h00;
    endcase
  end
  assign seg = raw ^ {7{INVERT}};
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 16,
  parameter bit INVERT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic                  load,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2((DIV > GAP ? DIV : GAP) + 1);
  typedef enum logic {S_GAP, S_SHOW} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] act_q, act_d, shd_q, shd_d;
  logic [DIGITS-1:0]   adp_q, adp_d, sdp_q, sdp_d;
  logic                pend_q, pend_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   zero_top;
  logic [3:0]          nib;
  logic [6:0]          hex_seg;
  logic                accept, slot_end, boundary, lit, blank, z;
  hex2digit #(.INVERT(INVERT)) u_hex (.nib(nib), .seg(hex_seg));
  always_comb begin
    accept   = load && !pend_q;
    slot_end = cnt_q == CW'(state_q == S_SHOW ? DIV - 1 : GAP - 1);
    boundary = state_q == S_GAP && slot_end && idx_q == '0;
    state_d  = slot_end ? (state_q == S_GAP ? S_SHOW : S_GAP) : state_q;
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = (state_q == S_SHOW && slot_end) ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    act_d    = (boundary && pend_q) ? shd_q : act_q;
    adp_d    = (boundary && pend_q) ? sdp_q : adp_q;
    shd_d    = accept ? value : shd_q;
    sdp_d    = accept ? dp_in : sdp_q;
    pend_d   = accept || (pend_q && !boundary);
    z        = 1'b1;
    zero_top = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z           = z && act_d[4*k +: 4] == 4'd0;
      zero_top[k] = z;
    end
    // outputs are computed from next-state so they register on the same edge as state/idx
    nib   = act_d[{idx_d, 2'b00} +: 4];
    lit   = state_d == S_SHOW;
    blank = lz_en && idx_d != '0 && zero_top[idx_d];
    an_d  = (lit ? DIGITS'(1) << idx_d : '0) ^ {DIGITS{INVERT}};
    seg_d = (lit && !blank) ? hex_seg : {7{INVERT}};
    dp_d  = (lit && adp_d[idx_d]) ^ INVERT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_GAP;
      cnt_q   <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      adp_q   <= '0;
      shd_q   <= '0;
      sdp_q   <= '0;
      pend_q  <= 1'b0;
      an_q    <= {DIGITS{INVERT}};
      seg_q   <= {7{INVERT}};
      dp_q    <= INVERT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      adp_q   <= adp_d;
      shd_q   <= shd_d;
      sdp_q   <= sdp_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end
  assign ready = !pend_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed stimulus with a slot scoreboard; the monitor pops one expectation per lit slot.
module tb_seg_scan_ctrl;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic        ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  slot_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cur = 0;
  seg_scan_ctrl #(.DIGITS(4), .DIV(4), .GAP(1), .INVERT(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_en(lz_en),
    .load(load), .ready(ready), .seg(seg), .dp(dp), .an(an)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic lz, input int n);
    slot_t e;
    logic  blank;
    for (int k = 0; k < n; k++) begin
      blank  = lz && k > 0 && (v >> (4 * k)) == 16'd0;
      e.an   = ~(4'b0001 << k);
      e.seg  = blank ? 7'h7F : enc(v[4*k +: 4]);
      e.dp   = ~d[k];
      sb.push_back(e);
    end
  endtask
  task automatic goto(input int e);
    repeat (e - cur) @(posedge clk);
    cur = e;
    #1;
  endtask
  task automatic chk_reset_out(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_ready"}, 32'(ready), 32'h1);
  endtask
  // Slot tracker: pops on the first lit cycle of every slot, checks slot/gap lengths and dark outputs.
  logic [3:0] prev_an = 4'hF;
  int         lit_n = 0;
  int         dark_n = 0;
  always @(negedge clk) begin
    slot_t e;
    if (rst) begin
      prev_an = 4'hF;
      lit_n   = 0;
      dark_n  = 0;
    end else begin
      if (an != 4'hF) begin
        if (prev_an == 4'hF) begin
          chk("gap_len", 32'(dark_n), 32'd1);
          if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
          else begin
            e = sb.pop_front();
            chk("slot_an", 32'(an), 32'(e.an));
            chk("slot_seg", 32'(seg), 32'(e.seg));
            chk("slot_dp", 32'(dp), 32'(e.dp));
          end
          lit_n  = 0;
          dark_n = 0;
        end else chk("an_stable", 32'(an), 32'(prev_an));
        lit_n++;
      end else begin
        if (prev_an != 4'hF) chk("show_len", 32'(lit_n), 32'd4);
        chk("gap_seg", 32'(seg), 32'h7F);
        chk("gap_dp", 32'(dp), 32'h1);
        dark_n++;
      end
      prev_an = an;
    end
  end
  initial begin
    load  = 1'b1;
    value = 16'hABCD;
    dp_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    load  = 1'b0;
    value = '0;
    dp_in = '0;
    cur   = 0;
    chk_reset_out("rst1");
    push_frame(16'h0000, 4'h0, 1'b0, 4);
    push_frame(16'h12AF, 4'h0, 1'b0, 4);
    goto(7);
    load  = 1'b1;
    value = 16'h12AF;
    goto(8);
    chk("ready_after_load", 32'(ready), 32'h0);
    value = 16'hFFFF;
    dp_in = 4'hF;
    goto(9);
    chk("ready_ignored_load", 32'(ready), 32'h0);
    load  = 1'b0;
    value = '0;
    dp_in = '0;
    goto(21);
    chk("ready_after_boundary", 32'(ready), 32'h1);
    push_frame(16'h12AF, 4'h0, 1'b1, 4);
    goto(40);
    load  = 1'b1;
    value = 16'h0050;
    dp_in = 4'b1000;
    lz_en = 1'b1;
    goto(41);
    load  = 1'b0;
    chk("ready_load_at_boundary", 32'(ready), 32'h0);
    push_frame(16'h0050, 4'b1000, 1'b1, 4);
    goto(61);
    chk("ready_next_boundary", 32'(ready), 32'h1);
    goto(64);
    load  = 1'b1;
    value = 16'h0000;
    dp_in = 4'h0;
    goto(65);
    load  = 1'b0;
    push_frame(16'h0000, 4'h0, 1'b1, 4);
    push_frame(16'h0000, 4'h0, 1'b1, 3);
    goto(102);
    load  = 1'b1;
    value = 16'h1234;
    dp_in = 4'hF;
    goto(103);
    load  = 1'b0;
    chk("ready_pending", 32'(ready), 32'h0);
    goto(112);
    rst = 1'b1;
    goto(113);
    rst = 1'b0;
    chk_reset_out("rst2");
    push_frame(16'h0000, 4'h0, 1'b1, 4);
    goto(133);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
